// File: rtl/mc_control.sv
// Multi-cycle RV32I control unit: walks each instruction through fetch, decode, execute and
// writeback states and drives the datapath enables, operand muxes and ALU control code.
module mc_control (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic       o_pc_write,
  output logic       o_adr_src,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_write,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_imm_src,
  output logic [2:0] o_alu_control,
  output logic       o_illegal_op,
  output logic [3:0] o_state
);

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_EXECR    = 4'd6;
  localparam logic [3:0] ST_EXECI    = 4'd7;
  localparam logic [3:0] ST_ALUWB    = 4'd8;
  localparam logic [3:0] ST_JAL      = 4'd9;
  localparam logic [3:0] ST_BEQ      = 4'd10;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_illegal;
  logic [1:0] w_result_src;
  logic [1:0] w_src_a;
  logic [1:0] w_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_imm_src;
  logic [2:0] w_alu_control;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = ST_FETCH;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_result_src = 2'b00;
    w_src_a      = 2'b00;
    w_src_b      = 2'b00;
    w_alu_op     = 2'b00;
    case (r_state)
      ST_FETCH: begin
        w_ir_write   = 1'b1;
        w_src_b      = 2'b10;
        w_result_src = 2'b10;
        w_pc_update  = 1'b1;
        w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        // Precompute the branch target into alu_out while the opcode is decoded.
        w_src_a = 2'b01;
        w_src_b = 2'b01;
        case (i_op)
          OP_LW, OP_SW: w_next_state = ST_MEMADR;
          OP_RTYP:      w_next_state = ST_EXECR;
          OP_ITYP:      w_next_state = ST_EXECI;
          OP_JAL:       w_next_state = ST_JAL;
          OP_BEQ:       w_next_state = ST_BEQ;
          default: begin
            w_illegal    = 1'b1;
            w_next_state = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        w_src_a      = 2'b10;
        w_src_b      = 2'b01;
        w_next_state = i_op[5] ? ST_MEMWRITE : ST_MEMREAD;
      end
      ST_MEMREAD: begin
        w_adr_src    = 1'b1;
        w_next_state = ST_MEMWB;
      end
      ST_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      ST_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      ST_EXECR: begin
        w_src_a      = 2'b10;
        w_src_b      = 2'b00;
        w_alu_op     = 2'b10;
        w_next_state = ST_ALUWB;
      end
      ST_EXECI: begin
        w_src_a      = 2'b10;
        w_src_b      = 2'b01;
        w_alu_op     = 2'b10;
        w_next_state = ST_ALUWB;
      end
      ST_ALUWB: begin
        w_reg_write = 1'b1;
      end
      ST_JAL: begin
        w_src_a      = 2'b01;
        w_src_b      = 2'b10;
        w_pc_update  = 1'b1;
        w_next_state = ST_ALUWB;
      end
      ST_BEQ: begin
        w_src_a  = 2'b10;
        w_src_b  = 2'b00;
        w_alu_op = 2'b01;
        w_branch = 1'b1;
      end
      default: w_next_state = ST_FETCH;
    endcase
  end

  always_comb begin
    w_alu_control = 3'b000;
    case (w_alu_op)
      2'b01: w_alu_control = 3'b001;
      2'b10: begin
        case (i_funct3)
          3'b000:  w_alu_control = (i_op[5] & i_funct7b5) ? 3'b001 : 3'b000;
          3'b010:  w_alu_control = 3'b101;
          3'b110:  w_alu_control = 3'b011;
          3'b111:  w_alu_control = 3'b010;
          default: w_alu_control = 3'b000;
        endcase
      end
      default: w_alu_control = 3'b000;
    endcase
  end

  always_comb begin
    case (i_op)
      OP_SW:   w_imm_src = 2'b01;
      OP_BEQ:  w_imm_src = 2'b10;
      OP_JAL:  w_imm_src = 2'b11;
      default: w_imm_src = 2'b00;
    endcase
  end

  // Reset blanks every output so nothing is written while rst is held.
  assign o_pc_write    = ~i_rst & (w_pc_update | (w_branch & i_zero));
  assign o_adr_src     = ~i_rst & w_adr_src;
  assign o_mem_write   = ~i_rst & w_mem_write;
  assign o_ir_write    = ~i_rst & w_ir_write;
  assign o_reg_write   = ~i_rst & w_reg_write;
  assign o_illegal_op  = ~i_rst & w_illegal;
  assign o_result_src  = i_rst ? 2'b00 : w_result_src;
  assign o_alu_src_a   = i_rst ? 2'b00 : w_src_a;
  assign o_alu_src_b   = i_rst ? 2'b00 : w_src_b;
  assign o_imm_src     = i_rst ? 2'b00 : w_imm_src;
  assign o_alu_control = i_rst ? 3'b000 : w_alu_control;
  assign o_state       = i_rst ? 4'd0 : r_state;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each supported instruction class through its states
// and compares control outputs against hand-derived values.
module tb_mc_control;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       illegal_op;
  logic [3:0] state;

  int n_total = 0;
  int n_bad   = 0;

  mc_control u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_op         (op),
    .i_funct3     (funct3),
    .i_funct7b5   (funct7b5),
    .i_zero       (zero),
    .o_pc_write   (pc_write),
    .o_adr_src    (adr_src),
    .o_mem_write  (mem_write),
    .o_ir_write   (ir_write),
    .o_reg_write  (reg_write),
    .o_result_src (result_src),
    .o_alu_src_a  (alu_src_a),
    .o_alu_src_b  (alu_src_b),
    .o_imm_src    (imm_src),
    .o_alu_control(alu_control),
    .o_illegal_op (illegal_op),
    .o_state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {11'd0, pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
            alu_src_b, imm_src, alu_control, illegal_op, state};
  endfunction

  initial begin
    rst = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    #1;
    check("rst_outs0", all_outs(), 32'd0);
    step();
    check("rst_outs1", all_outs(), 32'd0);
    step();
    check("rst_outs2", all_outs(), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_ir_write", 32'(ir_write), 32'd1);
    check("post_rst_pc_write", 32'(pc_write), 32'd1);
    check("post_rst_src_b", 32'(alu_src_b), 32'd2);
    check("fetch_result_src", 32'(result_src), 32'd2);
    check("fetch_alu_ctl", 32'(alu_control), 32'd0);

    // lw: 0,1,2,3,4,0
    step();
    check("lw_decode", 32'(state), 32'd1);
    check("lw_decode_ab", 32'({alu_src_a, alu_src_b}), 32'b0101);
    check("lw_decode_pcw", 32'(pc_write), 32'd0);
    step();
    check("lw_memadr", 32'(state), 32'd2);
    check("lw_memadr_ab", 32'({alu_src_a, alu_src_b}), 32'b1001);
    step();
    check("lw_memread", 32'(state), 32'd3);
    check("lw_memread_adr", 32'(adr_src), 32'd1);
    check("lw_memread_mw", 32'(mem_write), 32'd0);
    step();
    check("lw_memwb", 32'(state), 32'd4);
    check("lw_memwb_rw", 32'(reg_write), 32'd1);
    check("lw_memwb_rs", 32'(result_src), 32'd1);
    check("lw_memwb_mw", 32'(mem_write), 32'd0);
    step();
    check("lw_fetch", 32'(state), 32'd0);

    // sw: 0,1,2,5,0
    op = 7'b0100011;
    #1;
    check("sw_fetch_mw", 32'(mem_write), 32'd0);
    step();
    check("sw_decode_mw", 32'(mem_write), 32'd0);
    step();
    check("sw_memadr", 32'(state), 32'd2);
    step();
    check("sw_memwrite", 32'(state), 32'd5);
    check("sw_memwrite_mw", 32'(mem_write), 32'd1);
    check("sw_memwrite_adr", 32'(adr_src), 32'd1);
    check("sw_imm_src", 32'(imm_src), 32'd1);
    check("sw_memwrite_rw", 32'(reg_write), 32'd0);
    step();
    check("sw_fetch", 32'(state), 32'd0);

    // R-type sub then slt
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    step();
    step();
    check("r_execr", 32'(state), 32'd6);
    check("r_sub_ctl", 32'(alu_control), 32'd1);
    check("r_execr_ab", 32'({alu_src_a, alu_src_b}), 32'b1000);
    step();
    check("r_aluwb", 32'(state), 32'd8);
    check("r_aluwb_rw", 32'(reg_write), 32'd1);
    check("r_aluwb_rs", 32'(result_src), 32'd0);
    step();
    check("r_fetch", 32'(state), 32'd0);
    funct3 = 3'b010;
    step();
    step();
    check("r_slt_ctl", 32'(alu_control), 32'd5);
    funct3 = 3'b110;
    #1;
    check("r_or_ctl", 32'(alu_control), 32'd3);
    funct3 = 3'b111;
    #1;
    check("r_and_ctl", 32'(alu_control), 32'd2);
    funct3 = 3'b001;
    #1;
    check("r_other_ctl", 32'(alu_control), 32'd0);
    step();
    step();

    // I-type addi with funct7b5=1 must still add
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    step();
    step();
    check("i_execi", 32'(state), 32'd7);
    check("i_add_ctl", 32'(alu_control), 32'd0);
    check("i_execi_ab", 32'({alu_src_a, alu_src_b}), 32'b1001);
    step();
    check("i_aluwb", 32'(state), 32'd8);
    step();

    // jal: 0,1,9,8,0
    op = 7'b1101111;
    step();
    step();
    check("jal_state", 32'(state), 32'd9);
    check("jal_pcw", 32'(pc_write), 32'd1);
    check("jal_ab", 32'({alu_src_a, alu_src_b}), 32'b0110);
    check("jal_imm", 32'(imm_src), 32'd3);
    step();
    check("jal_aluwb", 32'(state), 32'd8);
    step();
    check("jal_fetch", 32'(state), 32'd0);

    // beq taken then not taken
    op = 7'b1100011; zero = 1'b1;
    step();
    step();
    check("beq_state", 32'(state), 32'd10);
    check("beq_taken_pcw", 32'(pc_write), 32'd1);
    check("beq_ctl", 32'(alu_control), 32'd1);
    check("beq_imm", 32'(imm_src), 32'd2);
    step();
    check("beq_next", 32'(state), 32'd0);
    zero = 1'b0;
    step();
    step();
    check("beq_nt_state", 32'(state), 32'd10);
    check("beq_nt_pcw", 32'(pc_write), 32'd0);
    step();
    check("beq_nt_next", 32'(state), 32'd0);

    // illegal opcode
    op = 7'b1111111;
    #1;
    check("ill_fetch_flag", 32'(illegal_op), 32'd0);
    step();
    check("ill_decode_flag", 32'(illegal_op), 32'd1);
    step();
    check("ill_next_state", 32'(state), 32'd0);
    check("ill_next_flag", 32'(illegal_op), 32'd0);

    // reset pulsed in MEMREAD aborts the load
    op = 7'b0000011;
    step();
    step();
    step();
    check("abort_memread", 32'(state), 32'd3);
    rst = 1'b1;
    #1;
    check("abort_rst_outs", all_outs(), 32'd0);
    step();
    check("abort_rst_rw", 32'(reg_write), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_fetch", 32'(state), 32'd0);
    check("abort_ir_write", 32'(ir_write), 32'd1);
    check("abort_rw", 32'(reg_write), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
